tt_gate_arbiter: RTL and testbench
==================================

Name: tt_gate_arbiter

Overview:
- Round-robin arbiter that shares the single gated output channel (uo_out gate path) among N_REQ requesters.
- Each requester raises req. The arbiter issues a registered one-hot grant, enforces a maximum hold time and a one-cycle turnaround, and honours a global inhibit (the ~ui_in[4] style gate qualifier).
- Sits between the tt_um top-level input decode and the output gate mux.

Parameters:
- N_REQ, 4, number of requesters; legal 2..8.
- MAX_HOLD, 8, maximum consecutive cycles one grant may stay high; legal 2..255.
- ID_W, $clog2(N_REQ), width of gnt_id.
- CNT_W, $clog2(MAX_HOLD), width of the hold counter.

Ports:
- clk  input  1  rising-edge clock; all logic in this single domain.
- rst  input  1  synchronous active-high reset, sampled on rising clk.
- req  input  N_REQ  request per requester; level, held high while use is wanted.
- inhibit  input  1  global inhibit; blocks new grants and revokes the current grant.
- gnt  output  N_REQ  one-hot grant, registered; all zero when idle.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  ID_W  index of the granted requester; 0 when gnt_valid=0.
- busy  output  1  high in GRANT and RELEASE states.
- timeout  output  1  one-cycle pulse when a grant was forcibly ended by MAX_HOLD.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; gnt=0, gnt_valid=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0.
  - ptr=N_REQ-1, so requester 0 wins first.
  - Reset overrides every other event, including a live grant.
- States: IDLE, GRANT, RELEASE. All outputs are registered.
- IDLE:
  - At an edge with inhibit=0 and req!=0, the winner is the first set bit searching ptr+1, ptr+2, ... with modulo-N_REQ wrap.
  - Next state GRANT; gnt[winner]=1; gnt_id=winner; ptr=winner; hold_cnt=0.
  - Latency: req sampled high at edge k gives gnt high from edge k (visible in cycle k+1).
  - With inhibit=1 or req=0, stay in IDLE.
- GRANT, evaluated each edge, in priority order:
  - req[owner]=0: go to RELEASE, gnt=0, timeout=0 (normal release).
  - Else inhibit=1: go to RELEASE, gnt=0, timeout=0.
  - Else hold_cnt==MAX_HOLD-1: go to RELEASE, gnt=0, timeout=1. gnt has then been high exactly MAX_HOLD cycles.
  - Else stay in GRANT with hold_cnt+1.
  - Requests from other requesters never pre-empt the owner.
- RELEASE: one cycle, gnt=0, busy=1. Next state is IDLE unconditionally. timeout clears to 0 on leaving RELEASE.
- Minimum gap between two grants: 2 cycles low (RELEASE, then IDLE arbitration).
- Fairness: after a grant to i, every other requesting index gets a grant before i again. This includes after a timeout.
- req changes on non-owner lines during GRANT are ignored; they are only sampled in IDLE.
- gnt is never multi-hot; gnt_id always matches gnt.
- hold_cnt saturation is impossible by construction; it never exceeds MAX_HOLD-1.

Test Plan:
- Reset then req=4'b0001 held 3 cycles and dropped: gnt=0001 for 3 cycles, gnt_id=0, then RELEASE (busy=1, gnt=0), then IDLE, busy=0, timeout never set.
- req=4'b1111 held continuously, MAX_HOLD=8: grants rotate 0,1,2,3,0. Each gnt is high exactly 8 cycles, a timeout pulse follows each grant, and gnt is low for 2 cycles between grants.
- Owner 2 granted, req=4'b0100; inhibit raised on the 3rd grant cycle: gnt drops at the next edge, timeout=0. While inhibit stays 1 with req=0100, no new grant; after inhibit falls, the grant to 2 is reissued after 1 IDLE edge.
- Owner 1 granted, req[3] raised mid-grant: gnt stays 0010 until req[1] drops; then gnt=1000 appears 2 cycles after gnt falls.
- req[owner] drops on the same edge that hold_cnt==MAX_HOLD-1: normal release with timeout=0.
- rst=1 asserted during GRANT with hold_cnt=5: all outputs 0 at the next edge. With req=1111 afterwards, requester 0 wins first.

Source files
------------

// File: rtl/tt_gate_arbiter.sv
// tt_gate_arbiter
//   Round-robin arbiter that shares the single gated output channel among
//   N_REQ requesters. It issues a registered one-hot grant, limits how long
//   one grant may stay high, inserts a one-cycle release slot between grants,
//   and honours a global inhibit that blocks new grants and revokes a live one.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req       per-requester level request
//   inhibit   global inhibit: no new grant, current grant revoked
//   gnt       registered one-hot grant (zero when idle)
//   gnt_valid registered OR of gnt
//   gnt_id    index of the granted requester, 0 when gnt_valid=0
//   busy      high while in GRANT or RELEASE
//   timeout   one-cycle pulse (during RELEASE) after a forced end by MAX_HOLD
module tt_gate_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             inhibit,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  // Round-robin search: first requesting index after ptr, wrapping modulo N_REQ.
  logic               any_win;
  logic [ID_W-1:0]    win;
  int unsigned        idx;

  always_comb begin
    any_win = 1'b0;
    win     = '0;
    idx     = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (32'(ptr_q) + off) % N_REQ;
      if (!any_win && req[idx]) begin
        any_win = 1'b1;
        win     = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!inhibit && any_win) begin
          state_d  = S_GRANT;
          gnt_d    = N_REQ'(1) << win;
          gnt_id_d = win;
          ptr_d    = win;
          hold_d   = '0;
        end
      end
      S_GRANT: begin
        // Owner release and inhibit take precedence over the hold limit,
        // so a drop on the final hold cycle is a normal release.
        if (!req[gnt_id_q] || inhibit) begin
          state_d  = S_RELEASE;
          gnt_d    = '0;
          gnt_id_d = '0;
          hold_d   = '0;
        end else if (hold_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d   = S_RELEASE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        hold_d   = '0;
      end
    endcase

    gnt_valid_d = (state_d == S_GRANT);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= ID_W'(N_REQ - 1);
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_tt_gate_arbiter.sv
// Testbench for tt_gate_arbiter: a directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model
// that tracks the owner, how many cycles its grant has been high, and the
// last winner for round-robin distance.
module tb_tt_gate_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         inhibit;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  tt_gate_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .inhibit(inhibit),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: owner=-1 when nobody holds the channel; held counts cycles the
  // current grant has been visible; rel marks the mandatory dead cycle.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = N - 1;
  bit m_rel   = 1'b0;
  bit m_to    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic inh, input logic rs);
    int best, bestd, d;
    if (rs) begin
      m_owner = -1; m_held = 0; m_rel = 0; m_to = 0; m_last = N - 1;
    end else if (m_rel) begin
      m_rel = 0; m_to = 0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner] || inh) begin
        m_owner = -1; m_rel = 1; m_to = 0;
      end else if (m_held == MH) begin
        m_owner = -1; m_rel = 1; m_to = 1;
      end else begin
        m_held++;
      end
    end else if (!inh && r != 0) begin
      best = -1; bestd = N + 1;
      for (int i = 0; i < N; i++) begin
        d = (i - m_last - 1 + 2 * N) % N;
        if (r[i] && d < bestd) begin best = i; bestd = d; end
      end
      m_owner = best; m_last = best; m_held = 1;
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic inh, input logic rs);
    logic [N-1:0] eg;
    req = r; inhibit = inh; rst = rs;
    @(posedge clk);
    model_edge(r, inh, rs);
    #1;
    eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
    chk("m_gnt", 32'(gnt), 32'(eg));
    chk("m_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("m_gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("m_busy", 32'(busy), 32'(m_owner >= 0 || m_rel));
    chk("m_timeout", 32'(timeout), 32'(m_to));
  endtask

  typedef struct {
    logic         rs;
    logic [N-1:0] r;
    logic         inh;
    logic [N-1:0] g;
    logic [1:0]   id;
    logic         b;
    logic         to;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int prev, run, gap, ng, cur;
    int ids[5];
    logic [N-1:0] rr;

    req = '0; inhibit = 1'b0; rst = 1'b1;

    // Simple hold/release, then inhibit revoking owner 2.
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].r, tbl[i].inh, tbl[i].rs);
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
      chk($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("vec%0d_to", i), 32'(timeout), 32'(tbl[i].to));
    end

    // All requesting: rotation 0,1,2,3,0, MH-cycle holds, timeout, 2-cycle gaps.
    ids[0] = 0; ids[1] = 1; ids[2] = 2; ids[3] = 3; ids[4] = 0;
    cyc('0, 1'b0, 1'b1);
    prev = 0; run = 0; gap = 0; ng = 0;
    for (int c = 0; c < 50; c++) begin
      cyc(4'b1111, 1'b0, 1'b0);
      cur = int'(gnt_valid);
      if (cur != 0 && prev == 0) begin
        if (ng > 0) chk("rot_gap", 32'(gap), 32'd2);
        if (ng < 5) chk($sformatf("rot_id%0d", ng), 32'(gnt_id), 32'(ids[ng]));
        ng++; run = 1;
      end else if (cur != 0) begin
        run++;
      end else if (prev != 0) begin
        chk("rot_hold_len", 32'(run), 32'(MH));
        chk("rot_timeout", 32'(timeout), 32'd1);
        gap = 1;
      end else begin
        gap++;
      end
      prev = cur;
    end
    chk("rot_count", 32'(ng >= 5), 32'd1);

    // Non-owner request during a grant never pre-empts.
    cyc('0, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b0);
    chk("pre_first", 32'(gnt), 32'b0010);
    cyc(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1010, 1'b0, 1'b0);
      chk("pre_hold", 32'(gnt), 32'b0010);
    end
    cyc(4'b1000, 1'b0, 1'b0);
    chk("pre_fall", 32'(gnt), 32'b0000);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("pre_gap", 32'(gnt), 32'b0000);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("pre_next", 32'(gnt), 32'b1000);
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);

    // Owner drops on the same edge the hold limit would fire: normal release.
    cyc('0, 1'b0, 1'b1);
    for (int k = 0; k < MH; k++) cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("edge_drop_gnt", 32'(gnt), 32'd0);
    chk("edge_drop_to", 32'(timeout), 32'd0);
    chk("edge_drop_busy", 32'(busy), 32'd1);
    cyc('0, 1'b0, 1'b0);

    // Reset mid-grant (hold count 5), then requester 0 wins first.
    cyc(4'b0100, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    cyc(4'b1111, 1'b0, 1'b0);
    chk("rst_first_id", 32'(gnt_id), 32'd0);
    chk("rst_first_gnt", 32'(gnt), 32'b0001);
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);

    // Randomized traffic with sticky requests so holds often reach the limit.
    rr = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) rr = N'($urandom);
      cyc(rr, ($urandom_range(0, 11) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
